// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the buffered UART transmitter.
//   - state_t       : transmitter FSM states
//   - PAR_*         : parity mode encodings of cfg_parity (2'b11 acts as none)
//   - eff_len()     : clamps a requested word length to the legal range
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Lengths below 5 or above the synthesized width fall back to the full width.
    function automatic logic [3:0] eff_len(input logic [3:0] len, input int max_bits);
        if (int'(len) < 5 || int'(len) > max_bits)
            return 4'(max_bits);
        return len;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with first-word-fall-through read data.
//   Pushes while full and pops while empty are ignored. Pointers wrap
//   naturally because DEPTH is a power of two.
// Ports
//   i_clk, i_reset : clock, synchronous active-high reset (flushes contents)
//   i_push, i_data : write request and data
//   i_pop          : read request; o_data shows the head entry
//   o_full/o_empty : occupancy flags
//   o_count        : number of occupied entries
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//   FIFO-buffered UART transmitter. Words arrive on a valid/ready stream,
//   are queued, and are serialised LSB-first with runtime-selectable length,
//   parity, stop bits and baud divisor. Consecutive frames run back-to-back.
// Ports
//   clk_glb, reset  : clock, synchronous active-high reset
//   s_valid/s_ready : input handshake (s_ready = FIFO not full)
//   s_data          : word to send; bits above the frame length are ignored
//   cfg_div         : bit period is cfg_div+1 clocks
//   cfg_len         : data bits per frame (5..DATA_BITS, else DATA_BITS)
//   cfg_parity      : 00 none, 01 even, 10 odd, 11 none
//   cfg_stop2       : two stop bits when set
//   tx_out          : serial line, idles high
//   tx_busy         : frame in progress (frame load through last stop bit)
//   tx_done         : one-cycle pulse on the last cycle of the final stop bit
//   fifo_count      : queued words
// All cfg_* inputs are captured at frame load and held for the whole frame.
// tx_out/tx_done are registered from the FSM, so the line lags the FSM by
// one clock: the start bit appears two edges after a push into an idle,
// empty transmitter.
// ---------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk_glb,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [3:0]                    cfg_len,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    // FIFO interface
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_BITS-1:0]  w_fifo_data;
    logic                  w_load;

    // Frame parameters latched at load
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  r_baud;
    logic [DATA_BITS-1:0]  r_shift;
    logic [3:0]            r_len;
    logic [3:0]            r_bit_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_stop_cnt;

    // FSM and registered outputs
    state_t                r_state;
    state_t                w_next;
    logic                  w_line;
    logic                  w_last;
    logic                  w_tick;
    logic                  r_tx;
    logic                  r_done;

    // Load-time helpers
    logic [3:0]            w_len_eff;
    logic [DATA_BITS-1:0]  w_mask;
    logic                  w_par_xor;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_glb),
        .i_reset (reset),
        .i_push  (s_valid),
        .i_data  (s_data),
        .i_pop   (w_load),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign s_ready = !w_fifo_full;
    assign tx_out  = r_tx;
    assign tx_done = r_done;
    // r_done covers the final output cycle after the FSM has already left STOP.
    assign tx_busy = (r_state != ST_IDLE) || r_done;
    assign w_tick  = (r_baud == r_div);

    // Parity only covers the low w_len_eff bits of the word.
    assign w_len_eff = eff_len(cfg_len, DATA_BITS);
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_BITS; i++)
            w_mask[i] = (i < int'(w_len_eff));
    end
    assign w_par_xor = ^(w_fifo_data & w_mask);

    // FSM state register
    always_ff @(posedge clk_glb) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // FSM next state, line level and load/last strobes
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_line = 1'b1;
        w_last = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_load = 1'b1;
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_line = 1'b0;
                if (w_tick) w_next = ST_DATA;
            end
            ST_DATA: begin
                w_line = r_shift[0];
                if (w_tick && (r_bit_cnt == r_len - 4'd1))
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                w_line = r_par_bit;
                if (w_tick) w_next = ST_STOP;
            end
            ST_STOP: begin
                w_line = 1'b1;
                if (w_tick && (r_stop_cnt == r_stop2)) begin
                    w_last = 1'b1;
                    // Chain straight into the next frame when one is queued.
                    if (!w_fifo_empty) begin
                        w_load = 1'b1;
                        w_next = ST_START;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: baud counter, shift register, bit/stop counters, outputs
    always_ff @(posedge clk_glb) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_baud     <= '0;
            r_div      <= '0;
            r_shift    <= '0;
            r_len      <= 4'(DATA_BITS);
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_tx   <= w_line;
            r_done <= w_last;
            if (w_load) begin
                r_baud     <= '0;
                r_div      <= cfg_div;
                r_shift    <= w_fifo_data;
                r_len      <= w_len_eff;
                r_bit_cnt  <= '0;
                r_par_en   <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                r_par_bit  <= (cfg_parity == PAR_ODD) ? ~w_par_xor : w_par_xor;
                r_stop2    <= cfg_stop2;
                r_stop_cnt <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (w_tick) begin
                    r_baud <= '0;
                    if (r_state == ST_DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    if (r_state == ST_STOP)
                        r_stop_cnt <= 1'b1;
                end else begin
                    r_baud <= r_baud + DIV_WIDTH'(1);
                end
            end
        end
    end

endmodule
